// File: rtl/otter_pkg.sv
// Shared types for the OTTER execute-stage multiply/divide unit.
package otter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MF_MUL    = 3'b000,
        MF_MULH   = 3'b001,
        MF_MULHSU = 3'b010,
        MF_MULHU  = 3'b011,
        MF_DIV    = 3'b100,
        MF_DIVU   = 3'b101,
        MF_REM    = 3'b110,
        MF_REMU   = 3'b111
    } md_fun_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

endpackage

// File: rtl/otter_muldiv.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps on operand
// magnitudes, then a sign-fix cycle. Divide-by-zero and signed overflow finish at once.
module otter_muldiv
    import otter_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic [2:0]      MD_FUN,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    muldiv_state_t     state_q, state_d;
    md_fun_t           fun_q, fun_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    md_fun_t           fun_in;
    logic              a_sgn, b_sgn, a_neg_in, b_neg_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     sum, trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            fun_q    <= MF_MUL;
            cnt_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            fun_q    <= fun_d;
            cnt_q    <= cnt_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fun_d    = fun_q;
        cnt_d    = cnt_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;

        fun_in   = md_fun_t'(MD_FUN);
        a_sgn    = fun_in inside {MF_MUL, MF_MULH, MF_MULHSU, MF_DIV, MF_REM};
        b_sgn    = fun_in inside {MF_MUL, MF_MULH, MF_DIV, MF_REM};
        a_neg_in = a_sgn & A[XLEN-1];
        b_neg_in = b_sgn & B[XLEN-1];
        // 0x80000000 negates to itself, which is already its correct unsigned magnitude.
        a_mag    = a_neg_in ? -A : A;
        b_mag    = b_neg_in ? -B : B;

        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
        trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
        prod     = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quo      = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem      = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    fun_d   = fun_in;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    opb_d   = b_mag;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    cnt_d   = '0;
                    if (fun_in[2] && B == '0) begin
                        result_d = fun_in[1] ? A : '1;
                        state_d  = ST_DONE;
                    end else if ((fun_in == MF_DIV || fun_in == MF_REM) &&
                                 A == 32'h8000_0000 && B == '1) begin
                        result_d = fun_in[1] ? '0 : 32'h8000_0000;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                // Multiply: low half holds the shifting multiplier, product grows in from the top.
                // Divide: acc is {remainder, dividend/quotient}, quotient bits shift in at bit 0.
                if (!fun_q[2]) begin
                    acc_d = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
                end else if (!trial[XLEN]) begin
                    acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = ST_FIX;
            end
            ST_FIX: begin
                unique case (fun_q)
                    MF_MUL:                       result_d = prod[XLEN-1:0];
                    MF_MULH, MF_MULHSU, MF_MULHU: result_d = prod[2*XLEN-1:XLEN];
                    MF_DIV, MF_DIVU:              result_d = quo;
                    default:                      result_d = rem;
                endcase
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign BUSY   = (state_q != ST_IDLE);
    assign DONE   = (state_q == ST_DONE);
    assign RESULT = result_q;

endmodule

// File: tb/tb_otter_muldiv.sv
// Directed vector bench for otter_muldiv: results, latency, busy length, abort-on-reset.
module tb_otter_muldiv;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [2:0]  MD_FUN;
    logic [31:0] A, B;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int tests = 0;
    int fails = 0;

    otter_muldiv dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .MD_FUN(MD_FUN),
        .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
        string       name;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit special, input string nm);
        int lat, busy, dn;
        @(negedge CLK);
        MD_FUN = f; A = a; B = b; START = 1'b1;
        lat = -1; busy = 0; dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            START = 1'b0;
            A = $urandom; B = $urandom; MD_FUN = 3'($urandom);
            if (DONE) begin
                dn++;
                if (lat < 0) lat = i;
            end
            if (BUSY) busy++;
        end
        check({nm, " result"}, RESULT, exp);
        check({nm, " latency"}, 32'(lat), special ? 32'd0 : 32'd33);
        check({nm, " busy"}, 32'(busy), special ? 32'd1 : 32'd34);
        check({nm, " done_pulses"}, 32'(dn), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3"};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max"};
        vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mulh_m1_m1"};
        vecs[3]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, "div_m7_2"};
        vecs[4]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "rem_m7_2"};
        vecs[5]  = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, "divu_by0"};
        vecs[6]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1, "remu_by0"};
        vecs[7]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf"};
        vecs[8]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "rem_ovf"};
        vecs[9]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "mulhsu_m1_2"};
        vecs[10] = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, "mul_2p32_lo"};
        vecs[11] = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, "mulhu_2p32_hi"};
        vecs[12] = '{3'b101, 32'd100,       32'd7,        32'd14,        1'b0, "divu_100_7"};
        vecs[13] = '{3'b111, 32'd100,       32'd7,        32'd2,         1'b0, "remu_100_7"};
        vecs[14] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div_7_m2"};
        vecs[15] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "rem_7_m2"};
        vecs[16] = '{3'b100, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 1'b0, "div_min_2"};
        vecs[17] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min_min"};
        vecs[18] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, "div_by0"};
        vecs[19] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b1, "rem_by0"};

        RST_N = 1'b0; START = 1'b0; MD_FUN = '0; A = '0; B = '0;
        #12;
        check("reset busy", {31'b0, BUSY}, 32'd0);
        check("reset done", {31'b0, DONE}, 32'd0);
        check("reset result", RESULT, 32'd0);
        @(posedge CLK); #1 RST_N = 1'b1;

        for (int v = 0; v < NV; v++)
            run_op(vecs[v].fun, vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].special, vecs[v].name);

        // Abort sequence: a restart mid-run must be ignored, reset must clear outputs at once.
        begin
            int saw_done, not_busy;
            saw_done = 0; not_busy = 0;
            @(negedge CLK);
            MD_FUN = 3'b000; A = 32'd3; B = 32'd5; START = 1'b1;
            for (int i = 0; i < 21; i++) begin
                @(negedge CLK);
                START = 1'b0;
                if (i == 10) begin
                    MD_FUN = 3'b101; A = 32'd100; B = 32'd0; START = 1'b1;
                end
                if (DONE) saw_done++;
                if (!BUSY) not_busy++;
            end
            check("abort no_done", 32'(saw_done), 32'd0);
            check("abort restart_ignored", 32'(not_busy), 32'd0);
            #2 RST_N = 1'b0;
            #1;
            check("abort busy", {31'b0, BUSY}, 32'd0);
            check("abort done", {31'b0, DONE}, 32'd0);
            check("abort result", RESULT, 32'd0);
            @(posedge CLK);
            check("abort held_done", {31'b0, DONE}, 32'd0);
            #1 RST_N = 1'b1;
        end
        run_op(3'b000, 32'd3, 32'd5, 32'd15, 1'b0, "post_reset_mul");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
